// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared parameter defaults and FSM state encoding for the SRAM access controller
// Purpose: the defaults used by sram_access_ctrl and its access-sequencer state type.
// Ports:   none (package).
package sram_ctrl_pkg;

   localparam int DEF_ADDR_W  = 19;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_N_PORTS = 2;
   localparam int DEF_WRAP    = 0;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_SETUP = 3'd1,
      WR_PULSE = 3'd2,
      WR_DONE  = 3'd3,
      RD_ADDR  = 3'd4,
      RD_LATCH = 3'd5,
      RD_DONE  = 3'd6
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant and grant-qualified pointer
// Purpose: picks one of N requesters, searching from the index after the last grant.
// Ports:   clk, rst (sync active-high), en (grant allowed this cycle),
//          req[N] request vector, gnt[N] one-hot grant (combinational, zero when !en).
module rr_arbiter #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);

   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [N-1:0] ONE = 1;

   logic [PTR_W-1:0] ptr_q, ptr_d;

   always_comb begin
      int         idx;
      logic       found;
      logic [N-1:0] sh;
      idx   = 0;
      found = 1'b0;
      sh    = '0;
      gnt   = '0;
      ptr_d = ptr_q;
      for (int i = 0; i < N; i++) begin
         // Candidate index rotated so the search starts at the pointer.
         idx = int'(ptr_q) + i;
         if (idx >= N) idx = idx - N;
         sh = req >> idx;
         if (en && !found && sh[0]) begin
            found = 1'b1;
            gnt   = ONE << idx;
            ptr_d = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - multi-port asynchronous SRAM access sequencer with auto-incrementing address
// Purpose: arbitrates N_PORTS write requesters and one pending read onto a single SRAM,
//          sequencing WE_n/OE_n/DQ_OE in fixed one-cycle states; all outputs registered.
// Ports:   CLOCK, RESET (sync active-high); WR_REQ/WR_DATA/WR_ACK per-port write handshake;
//          RD_REQ pulse, RD_DATA/RD_VALID read result; ADDR_LOAD/ADDR_LOAD_VAL address load;
//          SRAM_A, SRAM_DQ_OUT/IN, SRAM_DQ_OE, SRAM_WE_n, SRAM_OE_n pad side;
//          EMPTY, FULL, OVERFLOW (sticky), BUSY status.
module sram_access_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int N_PORTS = DEF_N_PORTS,
   parameter int WRAP    = DEF_WRAP
) (
   input  logic                      CLOCK,
   input  logic                      RESET,
   input  logic [N_PORTS-1:0]        WR_REQ,
   input  logic [N_PORTS*DATA_W-1:0] WR_DATA,
   output logic [N_PORTS-1:0]        WR_ACK,
   input  logic                      RD_REQ,
   output logic [DATA_W-1:0]         RD_DATA,
   output logic                      RD_VALID,
   input  logic                      ADDR_LOAD,
   input  logic [ADDR_W-1:0]         ADDR_LOAD_VAL,
   output logic [ADDR_W-1:0]         SRAM_A,
   output logic [DATA_W-1:0]         SRAM_DQ_OUT,
   input  logic [DATA_W-1:0]         SRAM_DQ_IN,
   output logic                      SRAM_DQ_OE,
   output logic                      SRAM_WE_n,
   output logic                      SRAM_OE_n,
   output logic                      EMPTY,
   output logic                      FULL,
   output logic                      OVERFLOW,
   output logic                      BUSY
);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   dq_out_q, dq_out_d;
   logic [DATA_W-1:0]   rd_data_q, rd_data_d;
   logic [N_PORTS-1:0]  wr_sel_q, wr_sel_d;
   logic [N_PORTS-1:0]  wr_ack_q, wr_ack_d;
   logic                rd_pend_q, rd_pend_d;
   logic                rd_valid_q, rd_valid_d;
   logic                full_q, full_d;
   logic                ovf_q, ovf_d;
   logic                empty_q, empty_d;
   logic                busy_q, busy_d;
   logic                we_n_q, we_n_d;
   logic                oe_n_q, oe_n_d;
   logic                dq_oe_q, dq_oe_d;

   logic [N_PORTS:0]    arb_req, arb_gnt;
   logic                arb_en;

   // A fresh RD_REQ competes in the same cycle it arrives; the pending flag covers later cycles.
   assign arb_req = {rd_pend_q | RD_REQ, WR_REQ};
   // An address load in IDLE takes the cycle; any coincident request is granted next cycle.
   assign arb_en  = (state_q == IDLE) && !ADDR_LOAD;

   rr_arbiter #(.N(N_PORTS + 1)) u_arb (
      .clk (CLOCK),
      .rst (RESET),
      .en  (arb_en),
      .req (arb_req),
      .gnt (arb_gnt)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      dq_out_d  = dq_out_q;
      rd_data_d = rd_data_q;
      wr_sel_d  = wr_sel_q;
      rd_pend_d = rd_pend_q;
      full_d    = full_q;
      ovf_d     = ovf_q;

      case (state_q)
         IDLE: begin
            if (ADDR_LOAD) begin
               addr_d = ADDR_LOAD_VAL;
               full_d = 1'b0;
               ovf_d  = 1'b0;
            end else if (arb_gnt[N_PORTS]) begin
               state_d   = RD_ADDR;
               rd_pend_d = 1'b0;
            end else if (|arb_gnt[N_PORTS-1:0]) begin
               wr_sel_d = arb_gnt[N_PORTS-1:0];
               for (int i = 0; i < N_PORTS; i++) begin
                  if (arb_gnt[i]) dq_out_d = WR_DATA[i*DATA_W +: DATA_W];
               end
               // A full, non-wrapping memory drops the write: straight to the ack state, no WE_n pulse.
               if (full_q) begin
                  state_d = WR_DONE;
                  ovf_d   = 1'b1;
               end else begin
                  state_d = WR_SETUP;
               end
            end
         end
         WR_SETUP: state_d = WR_PULSE;
         WR_PULSE: state_d = WR_DONE;
         RD_ADDR:  state_d = RD_LATCH;
         RD_LATCH: begin
            state_d   = RD_DONE;
            rd_data_d = SRAM_DQ_IN;
         end
         WR_DONE, RD_DONE: begin
            state_d = IDLE;
            // FULL is only ever set on leaving a DONE state, so it being set here means
            // the access happened at the saturated top address: leave the address alone.
            if (!full_q) begin
               if (&addr_q) begin
                  if (WRAP != 0) begin
                     addr_d = '0;
                     ovf_d  = 1'b1;
                  end else begin
                     full_d = 1'b1;
                  end
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Only one read may be outstanding; repeats while pending are dropped.
      if (RD_REQ && !rd_pend_q && !arb_gnt[N_PORTS]) rd_pend_d = 1'b1;

      dq_oe_d    = (state_d == WR_SETUP) || (state_d == WR_PULSE) || (state_d == WR_DONE);
      we_n_d     = (state_d != WR_PULSE);
      oe_n_d     = !((state_d == RD_ADDR) || (state_d == RD_LATCH));
      busy_d     = (state_d != IDLE);
      wr_ack_d   = (state_d == WR_DONE) ? wr_sel_d : '0;
      rd_valid_d = (state_d == RD_DONE);
      empty_d    = (addr_d == '0) && !full_d;
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         dq_out_q   <= '0;
         rd_data_q  <= '0;
         wr_sel_q   <= '0;
         wr_ack_q   <= '0;
         rd_pend_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         empty_q    <= 1'b1;
         busy_q     <= 1'b0;
         we_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         dq_oe_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         dq_out_q   <= dq_out_d;
         rd_data_q  <= rd_data_d;
         wr_sel_q   <= wr_sel_d;
         wr_ack_q   <= wr_ack_d;
         rd_pend_q  <= rd_pend_d;
         rd_valid_q <= rd_valid_d;
         full_q     <= full_d;
         ovf_q      <= ovf_d;
         empty_q    <= empty_d;
         busy_q     <= busy_d;
         we_n_q     <= we_n_d;
         oe_n_q     <= oe_n_d;
         dq_oe_q    <= dq_oe_d;
      end
   end

   assign WR_ACK      = wr_ack_q;
   assign RD_DATA     = rd_data_q;
   assign RD_VALID    = rd_valid_q;
   assign SRAM_A      = addr_q;
   assign SRAM_DQ_OUT = dq_out_q;
   assign SRAM_DQ_OE  = dq_oe_q;
   assign SRAM_WE_n   = we_n_q;
   assign SRAM_OE_n   = oe_n_q;
   assign EMPTY       = empty_q;
   assign FULL        = full_q;
   assign OVERFLOW    = ovf_q;
   assign BUSY        = busy_q;

endmodule
